// File: rtl/it_pkg.sv
// Shared definitions for the Thumb-2 IT pre-decoder and ITSTATE sequencer.
package it_pkg;

    localparam int ITSTATE_W = 8;

    // Base condition codes, as encoded in IT firstcond and ITSTATE[7:4].
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Whether decode is currently inside an IT block.
    typedef enum logic {
        IT_IDLE   = 1'b0,
        IT_IN_BLK = 1'b1
    } it_phase_e;

    // An IT with firstcond NV or an empty mask cannot open a block.
    function automatic logic it_is_illegal(input logic [ITSTATE_W-1:0] status);
        return (status[7:4] == COND_NV) || (status[3:0] == 4'b0000);
    endfunction

    // Step ITSTATE past one block instruction: the condition LSB and mask
    // shift up together, and the block ends once the mask is exhausted.
    function automatic logic [ITSTATE_W-1:0] it_advance(input logic [ITSTATE_W-1:0] state);
        logic [ITSTATE_W-1:0] nxt;
        if (state[2:0] == 3'b000) begin
            nxt = '0;
        end else begin
            nxt = {state[7:5], state[3:0], 1'b0};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/it_tz_enc.sv
// Trailing-zero encoder turning the ITSTATE mask into the count of block
// instructions still to execute, current one included.
module it_tz_enc (
    input  logic [3:0] mask,
    output logic [2:0] remaining
);

    // The lowest set mask bit marks the block terminator; an empty mask means no block.
    always_comb begin
        remaining = 3'd0;
        casez (mask)
            4'b???1: remaining = 3'd4;
            4'b??10: remaining = 3'd3;
            4'b?100: remaining = 3'd2;
            4'b1000: remaining = 3'd1;
            default: remaining = 3'd0;
        endcase
    end

endmodule

// File: rtl/it_state_ctrl.sv
// ITSTATE (EPSR.IT) register with IT capture, per-instruction advance,
// exception save/restore and flush, feeding condition info back to decode.
module it_state_ctrl
    import it_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adv,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 it_flag,
    input  logic [ITSTATE_W-1:0] it_status,
    input  logic                 epsr_wr,
    input  logic [ITSTATE_W-1:0] epsr_it_in,
    output logic [3:0]           it_cond,
    output logic                 in_it_blk,
    output logic                 it_last,
    output logic [2:0]           it_remaining,
    output logic [ITSTATE_W-1:0] epsr_it,
    output logic                 it_err
);

    logic [ITSTATE_W-1:0] itstate;
    logic                 err_q;
    logic                 acc;
    it_phase_e            phase;

    assign acc   = adv & ~stall;
    assign phase = (itstate[3:0] != 4'b0000) ? IT_IN_BLK : IT_IDLE;

    // Priority: exception restore, then flush, then an accepted instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            itstate <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (epsr_wr) begin
                itstate <= epsr_it_in;
            end else if (flush) begin
                itstate <= '0;
            end else if (acc) begin
                case (phase)
                    IT_IDLE: begin
                        if (it_flag) begin
                            if (it_is_illegal(it_status)) begin
                                err_q <= 1'b1;
                            end else begin
                                itstate <= it_status;
                            end
                        end
                    end
                    IT_IN_BLK: begin
                        itstate <= it_advance(itstate);
                        if (it_flag) begin
                            err_q <= 1'b1;
                        end
                    end
                    default: itstate <= '0;
                endcase
            end
        end
    end

    it_tz_enc u_tz_enc (
        .mask      (itstate[3:0]),
        .remaining (it_remaining)
    );

    assign it_cond   = itstate[7:4];
    assign in_it_blk = (phase == IT_IN_BLK);
    assign it_last   = (itstate[3:0] == 4'b1000);
    assign epsr_it   = itstate;
    assign it_err    = err_q;

endmodule

// File: tb/tb_it_state_ctrl.sv
// Directed scoreboard bench for it_state_ctrl.
module tb_it_state_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       adv;
    logic       stall;
    logic       flush;
    logic       it_flag;
    logic [7:0] it_status;
    logic       epsr_wr;
    logic [7:0] epsr_it_in;
    logic [3:0] it_cond;
    logic       in_it_blk;
    logic       it_last;
    logic [2:0] it_remaining;
    logic [7:0] epsr_it;
    logic       it_err;

    typedef struct {
        string      tag;
        logic [7:0] it;
        logic       err;
        logic [2:0] rem;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    it_state_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .adv          (adv),
        .stall        (stall),
        .flush        (flush),
        .it_flag      (it_flag),
        .it_status    (it_status),
        .epsr_wr      (epsr_wr),
        .epsr_it_in   (epsr_it_in),
        .it_cond      (it_cond),
        .in_it_blk    (in_it_blk),
        .it_last      (it_last),
        .it_remaining (it_remaining),
        .epsr_it      (epsr_it),
        .it_err       (it_err)
    );

    always #5 clk = ~clk;

    // Queue the expected post-edge result.
    task automatic pushExpect(input string tag, input logic [7:0] it,
                              input logic err, input logic [2:0] rem);
        exp_t e;
        e.tag = tag;
        e.it  = it;
        e.err = err;
        e.rem = rem;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs, record what must follow, and step past the edge.
    task automatic applyStimulus(input string tag,
                                 input logic a, input logic s, input logic f,
                                 input logic fl, input logic [7:0] st,
                                 input logic wr, input logic [7:0] ein,
                                 input logic [7:0] exp_it, input logic exp_err,
                                 input logic [2:0] exp_rem);
        adv        = a;
        stall      = s;
        flush      = f;
        it_flag    = fl;
        it_status  = st;
        epsr_wr    = wr;
        epsr_it_in = ein;
        pushExpect(tag, exp_it, exp_err, exp_rem);
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expectation and compare every output against it.
    task automatic checkOutput();
        exp_t e;
        logic exp_blk;
        logic exp_last;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_empty: observed no entry, expected one");
        end
        if (sb.size() != 0) begin
            e        = sb.pop_front();
            exp_blk  = (e.it[3:0] != 4'b0000);
            exp_last = (e.it[3:0] == 4'b1000);
            checks++;
            assert (epsr_it === e.it) else begin
                errors++;
                $error("[TB] FAIL %s epsr_it: observed %h expected %h", e.tag, epsr_it, e.it);
            end
            checks++;
            assert (it_cond === e.it[7:4]) else begin
                errors++;
                $error("[TB] FAIL %s it_cond: observed %b expected %b", e.tag, it_cond, e.it[7:4]);
            end
            checks++;
            assert (in_it_blk === exp_blk) else begin
                errors++;
                $error("[TB] FAIL %s in_it_blk: observed %b expected %b", e.tag, in_it_blk, exp_blk);
            end
            checks++;
            assert (it_last === exp_last) else begin
                errors++;
                $error("[TB] FAIL %s it_last: observed %b expected %b", e.tag, it_last, exp_last);
            end
            checks++;
            assert (it_remaining === e.rem) else begin
                errors++;
                $error("[TB] FAIL %s it_remaining: observed %0d expected %0d", e.tag, it_remaining, e.rem);
            end
            checks++;
            assert (it_err === e.err) else begin
                errors++;
                $error("[TB] FAIL %s it_err: observed %b expected %b", e.tag, it_err, e.err);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        adv        = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        it_flag    = 1'b0;
        it_status  = 8'h00;
        epsr_wr    = 1'b0;
        epsr_it_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        pushExpect("reset", 8'h00, 1'b0, 3'd0);
        checkOutput();
        rst = 1'b0;

        // ITTE EQ: 0x06 -> 0x0C -> 0x18 -> 0x00
        applyStimulus("itte_load", 1,0,0,1,8'h06, 0,8'h00, 8'h06,0,3'd3); checkOutput();
        applyStimulus("itte_adv1", 1,0,0,0,8'h00, 0,8'h00, 8'h0C,0,3'd2); checkOutput();
        applyStimulus("itte_adv2", 1,0,0,0,8'h00, 0,8'h00, 8'h18,0,3'd1); checkOutput();
        applyStimulus("itte_end",  1,0,0,0,8'h00, 0,8'h00, 8'h00,0,3'd0); checkOutput();

        // Illegal ITs in IDLE: error pulses for one cycle only
        applyStimulus("ill_nv",       1,0,0,1,8'hF4, 0,8'h00, 8'h00,1,3'd0); checkOutput();
        applyStimulus("ill_nv_after", 1,0,0,0,8'h00, 0,8'h00, 8'h00,0,3'd0); checkOutput();
        applyStimulus("ill_mask0",    1,0,0,1,8'h30, 0,8'h00, 8'h00,1,3'd0); checkOutput();
        applyStimulus("ill_m0_after", 0,0,0,0,8'h00, 0,8'h00, 8'h00,0,3'd0); checkOutput();

        // Flush beats a legal IT in the same cycle
        applyStimulus("flush_vs_it", 1,0,1,1,8'h06, 0,8'h00, 8'h00,0,3'd0); checkOutput();
        // A stalled IT is not accepted
        applyStimulus("stall_it",    1,1,0,1,8'h06, 0,8'h00, 8'h00,0,3'd0); checkOutput();

        // Stall freezes ITSTATE at 0x0C, then flush clears it
        applyStimulus("st_load", 1,0,0,1,8'h06, 0,8'h00, 8'h06,0,3'd3); checkOutput();
        applyStimulus("st_adv",  1,0,0,0,8'h00, 0,8'h00, 8'h0C,0,3'd2); checkOutput();
        for (int i = 0; i < 3; i++) begin
            applyStimulus("st_hold", 1,1,0,0,8'h00, 0,8'h00, 8'h0C,0,3'd2); checkOutput();
        end
        applyStimulus("st_flush", 1,0,1,0,8'h00, 0,8'h00, 8'h00,0,3'd0); checkOutput();

        // Exception restore wins over flush and adv; low nibble 1000 leaves one instruction
        applyStimulus("epsr_rest", 1,0,1,0,8'h00, 1,8'h28, 8'h28,0,3'd1); checkOutput();
        applyStimulus("epsr_adv",  1,0,0,0,8'h00, 0,8'h00, 8'h00,0,3'd0); checkOutput();
        applyStimulus("epsr_ld2",  1,0,0,1,8'hA6, 0,8'h00, 8'hA6,0,3'd3); checkOutput();
        applyStimulus("epsr_zero", 1,0,0,0,8'h00, 1,8'h00, 8'h00,0,3'd0); checkOutput();

        // Nested IT inside block 0x06 advances and flags an error
        applyStimulus("nest_load", 1,0,0,1,8'h06, 0,8'h00, 8'h06,0,3'd3); checkOutput();
        applyStimulus("nest_it",   1,0,0,1,8'h48, 0,8'h00, 8'h0C,1,3'd2); checkOutput();
        applyStimulus("nest_idle", 0,0,0,0,8'h00, 0,8'h00, 8'h0C,0,3'd2); checkOutput();
        applyStimulus("nest_adv",  1,0,0,0,8'h00, 0,8'h00, 8'h18,0,3'd1); checkOutput();

        // Asynchronous reset mid-cycle at 0x18 clears everything before the next edge
        adv = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        pushExpect("async_rst", 8'h00, 1'b0, 3'd0);
        checkOutput();
        rst = 1'b0;
        applyStimulus("post_rst", 0,0,0,0,8'h00, 0,8'h00, 8'h00,0,3'd0); checkOutput();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
